// File: rtl/apb_regfile_slave.sv
// apb_regfile_slave
// APB slave exposing DEPTH registers of DATA_W bits each, with a configurable
// number of wait states per access phase.
//
// Ports:
//   pclk     - single clock, all state changes on its rising edge
//   preset   - synchronous active-high reset
//   psel     - slave select
//   penable  - access-phase strobe
//   pwrite   - 1 = write, 0 = read
//   paddr    - byte address (word index = paddr >> log2(DATA_W/8))
//   pwdata   - write data
//   pstrb    - byte write enables (ignored for reads)
//   pready   - registered transfer-complete, high for exactly one cycle
//   prdata   - registered read data, zero whenever pready is low
//   pslverr  - registered error for out-of-range or misaligned access

module apb_regfile_slave #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int DEPTH       = 32,
  parameter int WAIT_STATES = 0
) (
  input  logic                pclk,
  input  logic                preset,
  input  logic                psel,
  input  logic                penable,
  input  logic                pwrite,
  input  logic [ADDR_W-1:0]   paddr,
  input  logic [DATA_W-1:0]   pwdata,
  input  logic [DATA_W/8-1:0] pstrb,
  output logic                pready,
  output logic [DATA_W-1:0]   prdata,
  output logic                pslverr
);

  localparam int STRB_W = DATA_W / 8;
  localparam int OFF_W  = $clog2(STRB_W);
  localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((1 << OFF_W) - 1);
  localparam logic [ADDR_W-1:0] DEPTH_A  = ADDR_W'(DEPTH);
  localparam logic [3:0]        WS       = 4'(WAIT_STATES);

  typedef enum logic {
    IDLE,
    ACCESS
  } state_t;

  state_t state, state_next;
  logic [3:0] wait_cnt, wait_cnt_next;

  logic                write_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [STRB_W-1:0]   strb_q;

  logic [DATA_W-1:0]   regs [DEPTH];

  logic                pready_q;
  logic                pslverr_q;
  logic [DATA_W-1:0]   prdata_q;

  logic                setup;
  logic                load;
  logic                commit;
  logic                complete_next;
  logic [ADDR_W-1:0]   cur_addr;
  logic                cur_write;
  logic [ADDR_W-1:0]   word_idx;
  logic                in_range;
  logic [IDX_W-1:0]    idx;
  logic [DATA_W-1:0]   prdata_next;
  logic                pslverr_next;

  assign setup = psel && !penable;

  // With zero wait states the response is registered at the setup edge,
  // before the transfer attributes have been latched, so decode from the
  // live bus in IDLE and from the held copy during ACCESS.
  always_comb begin
    cur_addr  = (state == IDLE) ? paddr  : addr_q;
    cur_write = (state == IDLE) ? pwrite : write_q;
    word_idx  = cur_addr >> OFF_W;
    in_range  = ((cur_addr & OFF_MASK) == '0) && (word_idx < DEPTH_A);
    idx       = word_idx[IDX_W-1:0];
  end

  // complete_next marks the edge that starts the single pready cycle; a
  // wait count of 1 (or an already exhausted count) means the following
  // cycle is the completing one.
  always_comb begin
    state_next    = state;
    wait_cnt_next = wait_cnt;
    complete_next = 1'b0;
    load          = 1'b0;
    commit        = 1'b0;
    case (state)
      IDLE: begin
        if (setup) begin
          state_next    = ACCESS;
          wait_cnt_next = WS;
          load          = 1'b1;
          complete_next = (WS == 4'd0);
        end
      end
      ACCESS: begin
        if (pready_q) begin
          state_next = IDLE;
          commit     = write_q && in_range;
        end else if (!psel) begin
          state_next    = IDLE;
          wait_cnt_next = 4'd0;
        end else begin
          if (wait_cnt != 4'd0) begin
            wait_cnt_next = wait_cnt - 4'd1;
          end
          complete_next = penable && (wait_cnt <= 4'd1);
        end
      end
      default: begin
        state_next    = IDLE;
        wait_cnt_next = 4'd0;
      end
    endcase
  end

  always_comb begin
    prdata_next  = '0;
    pslverr_next = 1'b0;
    if (complete_next) begin
      pslverr_next = !in_range;
      if (in_range && !cur_write) begin
        prdata_next = regs[idx];
      end
    end
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      state     <= IDLE;
      wait_cnt  <= 4'd0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
      write_q   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      strb_q    <= '0;
      for (int r = 0; r < DEPTH; r++) begin
        regs[r] <= '0;
      end
    end else begin
      state     <= state_next;
      wait_cnt  <= wait_cnt_next;
      pready_q  <= complete_next;
      pslverr_q <= pslverr_next;
      prdata_q  <= prdata_next;
      if (load) begin
        write_q <= pwrite;
        addr_q  <= paddr;
        wdata_q <= pwdata;
        strb_q  <= pstrb;
      end
      if (commit) begin
        for (int b = 0; b < STRB_W; b++) begin
          if (strb_q[b]) begin
            regs[idx][b*8 +: 8] <= wdata_q[b*8 +: 8];
          end
        end
      end
    end
  end

  assign pready  = pready_q;
  assign prdata  = prdata_q;
  assign pslverr = pslverr_q;

endmodule

// File: tb/tb_apb_regfile_slave.sv
// tb_apb_regfile_slave
// Bench driving three apb_regfile_slave instances (0, 2 and 3 wait states)
// that share the APB bus signals but have their own psel and preset.
// Index 0 -> WAIT_STATES=0, index 1 -> WAIT_STATES=2, index 2 -> WAIT_STATES=3.

module tb_apb_regfile_slave;

  logic        pclk;
  logic [2:0]  preset_v;
  logic [2:0]  psel_v;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [2:0]  pready_v;
  logic [2:0]  pslverr_v;
  logic [31:0] prdata_v [3];

  int checks;
  int passes;

  apb_regfile_slave #(.DATA_W(32), .ADDR_W(32), .DEPTH(32), .WAIT_STATES(0)) dut0 (
    .pclk(pclk), .preset(preset_v[0]), .psel(psel_v[0]), .penable(penable),
    .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
    .pready(pready_v[0]), .prdata(prdata_v[0]), .pslverr(pslverr_v[0])
  );

  apb_regfile_slave #(.DATA_W(32), .ADDR_W(32), .DEPTH(32), .WAIT_STATES(2)) dut2 (
    .pclk(pclk), .preset(preset_v[1]), .psel(psel_v[1]), .penable(penable),
    .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
    .pready(pready_v[1]), .prdata(prdata_v[1]), .pslverr(pslverr_v[1])
  );

  apb_regfile_slave #(.DATA_W(32), .ADDR_W(32), .DEPTH(32), .WAIT_STATES(3)) dut3 (
    .pclk(pclk), .preset(preset_v[2]), .psel(psel_v[2]), .penable(penable),
    .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
    .pready(pready_v[2]), .prdata(prdata_v[2]), .pslverr(pslverr_v[2])
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  typedef struct {
    int          d;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] exp_rd;
    logic        exp_err;
    int          exp_wait;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input int d, input logic wr, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [3:0] strb,
                              input logic [31:0] exp_rd, input logic exp_err,
                              input int exp_wait);
    vec_t v;
    v.d = d; v.wr = wr; v.addr = addr; v.wdata = wdata; v.strb = strb;
    v.exp_rd = exp_rd; v.exp_err = exp_err; v.exp_wait = exp_wait;
    return v;
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) begin
      passes++;
    end else begin
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // One complete APB transfer on instance d; returns response, number of
  // pready-low access cycles and whether prdata/pslverr stayed zero then.
  task automatic do_xfer(input int d, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] strb,
                         output logic [31:0] rdata, output logic err,
                         output int waits, output logic quiet, output logic ok);
    @(negedge pclk);
    psel_v    = 3'b000;
    psel_v[d] = 1'b1;
    penable   = 1'b0;
    pwrite    = wr;
    paddr     = addr;
    pwdata    = wdata;
    pstrb     = strb;
    waits = 0; quiet = 1'b1; ok = 1'b0; rdata = '0; err = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge pclk);
      penable = 1'b1;
      if (pready_v[d]) begin
        rdata = prdata_v[d];
        err   = pslverr_v[d];
        ok    = 1'b1;
        break;
      end
      if (prdata_v[d] != 32'h0 || pslverr_v[d]) quiet = 1'b0;
      waits++;
    end
    if (!ok) begin
      checks++;
      $display("[TB] FAIL xfer_timeout: got no pready on dut %0d addr 0x%08h, expected pready within 40 cycles", d, addr);
    end
  endtask

  task automatic go_idle();
    @(negedge pclk);
    psel_v  = 3'b000;
    penable = 1'b0;
  endtask

  task automatic apply_stimulus(input vec_t v, input int n);
    logic [31:0] rd;
    logic        er, quiet, ok;
    int          w;
    do_xfer(v.d, v.wr, v.addr, v.wdata, v.strb, rd, er, w, quiet, ok);
    if (ok) begin
      check_output($sformatf("vec%0d_prdata", n), rd, v.exp_rd);
      check_output($sformatf("vec%0d_pslverr", n), 32'(er), 32'(v.exp_err));
      check_output($sformatf("vec%0d_waits", n), 32'(w), 32'(v.exp_wait));
      check_output($sformatf("vec%0d_quiet_while_waiting", n), 32'(quiet), 32'd1);
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL global_timeout: got simulation still running, expected completion");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic [31:0] rd;
    logic        er, quiet, ok, seen;
    int          w;

    checks = 0;
    passes = 0;
    preset_v = 3'b111;
    psel_v   = 3'b000;
    penable  = 1'b0;
    pwrite   = 1'b0;
    paddr    = '0;
    pwdata   = '0;
    pstrb    = '0;

    // Reset values on every instance
    repeat (3) @(negedge pclk);
    for (int d = 0; d < 3; d++) begin
      check_output($sformatf("reset_pready%0d", d), 32'(pready_v[d]), 32'd0);
      check_output($sformatf("reset_pslverr%0d", d), 32'(pslverr_v[d]), 32'd0);
      check_output($sformatf("reset_prdata%0d", d), prdata_v[d], 32'd0);
    end
    preset_v = 3'b000;

    // Back-to-back directed transfers
    vecs.push_back(mk(0, 1'b1, 32'h08, 32'hDEADBEEF, 4'hF, 32'h0,        1'b0, 0));
    vecs.push_back(mk(0, 1'b0, 32'h08, 32'h0,        4'hF, 32'hDEADBEEF, 1'b0, 0));
    vecs.push_back(mk(0, 1'b1, 32'h10, 32'h11223344, 4'hF, 32'h0,        1'b0, 0));
    vecs.push_back(mk(0, 1'b1, 32'h10, 32'hAABBCCDD, 4'h5, 32'h0,        1'b0, 0));
    vecs.push_back(mk(0, 1'b0, 32'h10, 32'h0,        4'h0, 32'h11BB33DD, 1'b0, 0));
    vecs.push_back(mk(0, 1'b1, 32'h80, 32'h12345678, 4'hF, 32'h0,        1'b1, 0));
    vecs.push_back(mk(0, 1'b1, 32'h02, 32'h12345678, 4'hF, 32'h0,        1'b1, 0));
    vecs.push_back(mk(0, 1'b0, 32'h80, 32'h0,        4'hF, 32'h0,        1'b1, 0));
    vecs.push_back(mk(0, 1'b0, 32'h03, 32'h0,        4'hF, 32'h0,        1'b1, 0));
    vecs.push_back(mk(0, 1'b1, 32'h7C, 32'h5A5A5A5A, 4'h8, 32'h0,        1'b0, 0));
    vecs.push_back(mk(0, 1'b0, 32'h7C, 32'h0,        4'hF, 32'h5A000000, 1'b0, 0));
    vecs.push_back(mk(0, 1'b0, 32'h08, 32'h0,        4'hF, 32'hDEADBEEF, 1'b0, 0));
    vecs.push_back(mk(0, 1'b0, 32'h00, 32'h0,        4'hF, 32'h0,        1'b0, 0));
    vecs.push_back(mk(2, 1'b0, 32'h04, 32'h0,        4'hF, 32'h0,        1'b0, 3));
    vecs.push_back(mk(2, 1'b1, 32'h04, 32'hCAFEF00D, 4'h3, 32'h0,        1'b0, 3));
    vecs.push_back(mk(2, 1'b0, 32'h04, 32'h0,        4'hF, 32'h0000F00D, 1'b0, 3));
    vecs.push_back(mk(2, 1'b1, 32'h84, 32'hFFFFFFFF, 4'hF, 32'h0,        1'b1, 3));
    for (int n = 0; n < vecs.size(); n++) begin
      apply_stimulus(vecs[n], n);
    end
    go_idle();
    check_output("pready_single_cycle", 32'(pready_v[2]), 32'd0);

    // psel dropped in first wait cycle of a write, then immediate read
    @(negedge pclk);
    psel_v = 3'b010; penable = 1'b0; pwrite = 1'b1;
    paddr = 32'h00; pwdata = 32'hA5A5A5A5; pstrb = 4'hF;
    @(negedge pclk);
    check_output("abort_pready", 32'(pready_v[1]), 32'd0);
    psel_v = 3'b000; penable = 1'b0;
    do_xfer(1, 1'b0, 32'h00, 32'h0, 4'hF, rd, er, w, quiet, ok);
    if (ok) begin
      check_output("abort_readback", rd, 32'h0);
      check_output("abort_read_waits", 32'(w), 32'd2);
      check_output("abort_read_pslverr", 32'(er), 32'd0);
    end
    go_idle();

    // Reset in the second access cycle of a write
    @(negedge pclk);
    psel_v = 3'b010; penable = 1'b0; pwrite = 1'b1;
    paddr = 32'h0C; pwdata = 32'hFFFFFFFF; pstrb = 4'hF;
    @(negedge pclk);
    penable = 1'b1;
    seen = pready_v[1];
    @(negedge pclk);
    seen = seen | pready_v[1];
    preset_v[1] = 1'b1;
    @(negedge pclk);
    preset_v[1] = 1'b0;
    psel_v = 3'b000; penable = 1'b0;
    for (int k = 0; k < 4; k++) begin
      seen = seen | pready_v[1];
      @(negedge pclk);
    end
    check_output("reset_midxfer_no_pready", 32'(seen), 32'd0);
    do_xfer(1, 1'b0, 32'h0C, 32'h0, 4'hF, rd, er, w, quiet, ok);
    if (ok) begin
      check_output("reset_midxfer_readback", rd, 32'h0);
      check_output("reset_midxfer_waits", 32'(w), 32'd2);
    end
    go_idle();

    // penable without a setup phase must be ignored
    @(negedge pclk);
    psel_v = 3'b001; penable = 1'b1; pwrite = 1'b1;
    paddr = 32'h00; pwdata = 32'hFFFFFFFF; pstrb = 4'hF;
    seen = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge pclk);
      seen = seen | pready_v[0];
    end
    check_output("no_setup_no_pready", 32'(seen), 32'd0);
    go_idle();
    do_xfer(0, 1'b0, 32'h00, 32'h0, 4'hF, rd, er, w, quiet, ok);
    if (ok) begin
      check_output("no_setup_no_write", rd, 32'h0);
    end
    go_idle();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
